// File: rtl/cond_logic.sv
// rtl/cond_logic.sv - condition evaluation, gated write enables, flag register and skip counter
//
// Purpose:
//   Evaluates the 4-bit condition field of each instruction against the
//   registered {N,Z,C,V} flags. Gates the decoder's PC/register/memory write
//   requests with the result, updates the flags from the ALU when the
//   instruction executes, and optionally counts squashed instructions.
//
// Configuration:
//   COND_SKIP_CNT_EN - when defined, builds the saturating skip counter.
//                      When undefined, skip_cnt is tied to 0 and skip_clr
//                      is ignored.
//
// Parameters:
//   CNT_W        width of the skip counter
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-high reset
//   instr_valid  an instruction is evaluated this cycle
//   cond         condition field
//   aluflags     ALU flags {N,Z,C,V}
//   flagw        bit1 writes N,Z; bit0 writes C,V
//   pcs/regw/memw          ungated write requests
//   pcsrc/regwrite/memwrite condition-gated write enables (combinational)
//   flags        registered {N,Z,C,V}
//   condex_q     registered condition result of the last valid instruction
//   skip_clr     synchronous clear of the skip counter
//   skip_cnt     number of instructions squashed by a failing condition

module cond_logic #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [3:0]       cond,
    input  logic [3:0]       aluflags,
    input  logic [1:0]       flagw,
    input  logic             pcs,
    input  logic             regw,
    input  logic             memw,
    output logic             pcsrc,
    output logic             regwrite,
    output logic             memwrite,
    output logic [3:0]       flags,
    output logic             condex_q,
    input  logic             skip_clr,
    output logic [CNT_W-1:0] skip_cnt
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       condex;
    logic       exec;
    logic       flag_n;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;

    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    // Evaluated only against registered flags, so a flag write never
    // affects the instruction that produced it.
    always_comb begin
        condex = 1'b0;
        unique case (cond)
            4'b0000: condex = flag_z;
            4'b0001: condex = ~flag_z;
            4'b0010: condex = flag_c;
            4'b0011: condex = ~flag_c;
            4'b0100: condex = flag_n;
            4'b0101: condex = ~flag_n;
            4'b0110: condex = flag_v;
            4'b0111: condex = ~flag_v;
            4'b1000: condex = flag_c & ~flag_z;
            4'b1001: condex = ~flag_c | flag_z;
            4'b1010: condex = (flag_n == flag_v);
            4'b1011: condex = (flag_n != flag_v);
            4'b1100: condex = ~flag_z & (flag_n == flag_v);
            4'b1101: condex = flag_z | (flag_n != flag_v);
            4'b1110: condex = 1'b1;
            4'b1111: condex = 1'b0;
            default: condex = 1'b0;
        endcase
    end

    assign exec     = instr_valid & condex;
    assign pcsrc    = pcs  & exec;
    assign regwrite = regw & exec;
    assign memwrite = memw & exec;

    always_comb begin
        flags_d = flags_q;
        if (exec) begin
            if (flagw[1]) flags_d[3:2] = aluflags[3:2];
            if (flagw[0]) flags_d[1:0] = aluflags[1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q  <= 4'b0000;
            condex_q <= 1'b0;
        end else begin
            flags_q <= flags_d;
            if (instr_valid) condex_q <= condex;
        end
    end

    assign flags = flags_q;

`ifdef COND_SKIP_CNT_EN
    logic [CNT_W-1:0] skip_cnt_q;
    logic [CNT_W-1:0] skip_cnt_d;

    // Clear has priority; the count sticks at all-ones instead of wrapping.
    always_comb begin
        skip_cnt_d = skip_cnt_q;
        if (skip_clr)
            skip_cnt_d = '0;
        else if (instr_valid && !condex && (skip_cnt_q != {CNT_W{1'b1}}))
            skip_cnt_d = skip_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) skip_cnt_q <= '0;
        else       skip_cnt_q <= skip_cnt_d;
    end

    assign skip_cnt = skip_cnt_q;
`else
    logic unused_skip_clr;
    assign unused_skip_clr = skip_clr;
    assign skip_cnt        = '0;
`endif

endmodule

// File: tb/tb_cond_logic.sv
// tb/tb_cond_logic.sv - self-checking bench for cond_logic with a behavioural model

module tb_cond_logic;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             instr_valid;
    logic [3:0]       cond;
    logic [3:0]       aluflags;
    logic [1:0]       flagw;
    logic             pcs, regw, memw;
    logic             pcsrc, regwrite, memwrite;
    logic [3:0]       flags;
    logic             condex_q;
    logic             skip_clr;
    logic [CNT_W-1:0] skip_cnt;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [3:0] m_flags;
    logic       m_cq;
    int         m_cnt;

    cond_logic #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .cond(cond),
        .aluflags(aluflags), .flagw(flagw), .pcs(pcs), .regw(regw), .memw(memw),
        .pcsrc(pcsrc), .regwrite(regwrite), .memwrite(memwrite), .flags(flags),
        .condex_q(condex_q), .skip_clr(skip_clr), .skip_cnt(skip_cnt)
    );

    always #5 clk = ~clk;

    // Condition as a base test selected by cond[3:1], inverted by cond[0].
    function automatic bit model_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_flags = 4'b0000;
        m_cq    = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic check_comb(input string tag);
        bit ce;
        ce = model_cond(cond, m_flags);
        chk({tag, ".pcsrc"},    16'(pcsrc),    16'(pcs  && instr_valid && ce));
        chk({tag, ".regwrite"}, 16'(regwrite), 16'(regw && instr_valid && ce));
        chk({tag, ".memwrite"}, 16'(memwrite), 16'(memw && instr_valid && ce));
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".flags"},    16'(flags),    16'(m_flags));
        chk({tag, ".condex_q"}, 16'(condex_q), 16'(m_cq));
        chk({tag, ".skip_cnt"}, 16'(skip_cnt), 16'(m_cnt));
    endtask

    // Called at posedge+1: settle, check gated outputs, clock, update model, check state.
    task automatic cycle(input string tag);
        bit ce;
        #1;
        check_comb(tag);
        ce = model_cond(cond, m_flags);
        @(posedge clk);
        if (instr_valid && ce) begin
            if (flagw[1]) m_flags[3:2] = aluflags[3:2];
            if (flagw[0]) m_flags[1:0] = aluflags[1:0];
        end
        if (instr_valid) m_cq = ce;
`ifdef COND_SKIP_CNT_EN
        if (skip_clr) m_cnt = 0;
        else if (instr_valid && !ce && m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
`endif
        #1;
        check_state(tag);
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [1:0] fw,
                         input logic [3:0] af, input logic [2:0] wr, input logic clr);
        instr_valid = v; cond = c; flagw = fw; aluflags = af;
        {pcs, regw, memw} = wr; skip_clr = clr;
    endtask

    localparam int EXP_ONE  = 0
`ifdef COND_SKIP_CNT_EN
        + 1
`endif
        ;
    localparam int EXP_FULL = EXP_ONE * 15;

    initial begin
        drive(1'b0, 4'b0000, 2'b00, 4'b0000, 3'b000, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        // Dirty the flags, then check that reset takes effect without a clock edge.
        drive(1'b1, 4'b1110, 2'b11, 4'b1111, 3'b000, 1'b0);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_state("async_reset");

        // Gated outputs stay live during reset against flags 0000.
        drive(1'b1, 4'b1110, 2'b00, 4'b0000, 3'b111, 1'b0);
        #1; chk("rst_al_pcsrc", 16'(pcsrc), 16'd1); check_comb("rst_al");
        cond = 4'b0001;
        #1; chk("rst_ne_regwrite", 16'(regwrite), 16'd1);
        cond = 4'b0000;
        #1; chk("rst_eq_memwrite", 16'(memwrite), 16'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // EQ fails from reset flags, counter bumps.
        drive(1'b1, 4'b0000, 2'b00, 4'b0000, 3'b010, 1'b0);
        #1; chk("eq_fail_regwrite", 16'(regwrite), 16'd0);
        cycle("eq_fail");
        chk("eq_fail_cnt", 16'(skip_cnt), 16'(EXP_ONE));

        // AL sets Z, then EQ passes.
        drive(1'b1, 4'b1110, 2'b11, 4'b0100, 3'b000, 1'b0);
        cycle("al_setz");
        chk("al_setz_flags", 16'(flags), 16'h4);
        drive(1'b1, 4'b0000, 2'b00, 4'b0000, 3'b001, 1'b0);
        #1; chk("eq_pass_memwrite", 16'(memwrite), 16'd1);
        cycle("eq_pass");

        // Only N,Z written.
        reset = 1'b1; #1; model_reset(); @(posedge clk); #1; reset = 1'b0;
        drive(1'b1, 4'b1110, 2'b10, 4'b1011, 3'b000, 1'b0);
        cycle("nz_only");
        chk("nz_only_flags", 16'(flags), 16'h8);

        // Signed compares.
        drive(1'b1, 4'b1110, 2'b11, 4'b1001, 3'b000, 1'b0);
        cycle("set_1001");
        drive(1'b1, 4'b1010, 2'b00, 4'b0000, 3'b100, 1'b0);
        #1; chk("ge_n1v1", 16'(pcsrc), 16'd1);
        cond = 4'b1011;
        #1; chk("lt_n1v1", 16'(pcsrc), 16'd0);
        cycle("lt");
        drive(1'b1, 4'b1110, 2'b11, 4'b1000, 3'b000, 1'b0);
        cycle("set_1000");
        drive(1'b1, 4'b1100, 2'b00, 4'b0000, 3'b100, 1'b0);
        #1; chk("gt_n1v0", 16'(pcsrc), 16'd0);
        cond = 4'b1101;
        #1; chk("le_n1v0", 16'(pcsrc), 16'd1);
        cycle("le");

        // Failing instruction must not write flags.
        drive(1'b1, 4'b0000, 2'b11, 4'b1111, 3'b100, 1'b0);
        #1; chk("fail_pcsrc", 16'(pcsrc), 16'd0);
        cycle("fail_nowrite");
        chk("fail_nowrite_flags", 16'(flags), 16'h8);

        // No same-cycle bypass: NE passes on old Z=0 while writing Z=1.
        drive(1'b1, 4'b0001, 2'b10, 4'b0100, 3'b100, 1'b0);
        #1; chk("nobypass_pcsrc", 16'(pcsrc), 16'd1);
        cycle("nobypass");
        chk("nobypass_flags", 16'(flags), 16'h4);

        // Invalid instruction: no writes, no condex_q update.
        drive(1'b0, 4'b1110, 2'b11, 4'b1011, 3'b111, 1'b0);
        cycle("invalid");
        chk("invalid_flags", 16'(flags), 16'h4);

        // Reset mid-cycle discards a pending update.
        drive(1'b1, 4'b1110, 2'b11, 4'b1111, 3'b000, 1'b0);
        #2; reset = 1'b1; #1; model_reset();
        @(posedge clk); #1; reset = 1'b0;
        check_state("midreset");
        chk("midreset_flags", 16'(flags), 16'h0);

        // Saturation and clear priority.
        drive(1'b1, 4'b1111, 2'b00, 4'b0000, 3'b111, 1'b0);
        for (int i = 0; i < 18; i++) cycle("sat");
        chk("sat_cnt", 16'(skip_cnt), 16'(EXP_FULL));
        skip_clr = 1'b1;
        cycle("clr");
        chk("clr_cnt", 16'(skip_cnt), 16'd0);
        skip_clr = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(3) != 0), 4'($urandom), 2'($urandom), 4'($urandom),
                  3'($urandom), ($urandom_range(15) == 0));
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
